// File: rtl/ifid_skid_reg_if.sv
// rtl/ifid_skid_reg_if.sv - fetch/decode handshake bundle for the IF/ID skid register
interface ifid_skid_reg_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [PC_W-1:0]    out_pc_next;
    logic [INSTR_W-1:0] out_instr;
    logic [1:0]         occupancy;

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_pc_next, out_instr, occupancy
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_pc_next, out_instr, occupancy
    );
endinterface

// File: rtl/ifid_skid_reg.sv
// rtl/ifid_skid_reg.sv - IF/ID pipeline register with two-entry skid buffer
module ifid_skid_reg #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int PC_STEP = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    ifid_skid_reg_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d, main_pcn_q, main_pcn_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d, skid_pcn_q, skid_pcn_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

    logic            accept;
    logic            pop;
    logic [PC_W-1:0] in_pcn;

    // in_ready comes from state alone so out_ready never reaches fetch combinationally
    assign accept = bus.in_valid && (state_q != FULL);
    assign pop    = (state_q != EMPTY) && bus.out_ready;
    assign in_pcn = bus.in_pc + STEP;

    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_pcn_d   = main_pcn_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_pcn_d   = skid_pcn_q;
        skid_instr_d = skid_instr_q;
        if (flush) begin
            state_d      = EMPTY;
            main_pc_d    = '0;
            main_pcn_d   = STEP;
            main_instr_d = '0;
            skid_pc_d    = '0;
            skid_pcn_d   = STEP;
            skid_instr_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d      = ONE;
                        main_pc_d    = bus.in_pc;
                        main_pcn_d   = in_pcn;
                        main_instr_d = bus.in_instr;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_pc_d    = bus.in_pc;
                        main_pcn_d   = in_pcn;
                        main_instr_d = bus.in_instr;
                    end else if (accept) begin
                        state_d      = FULL;
                        skid_pc_d    = bus.in_pc;
                        skid_pcn_d   = in_pcn;
                        skid_instr_d = bus.in_instr;
                    end else if (pop) begin
                        state_d      = EMPTY;
                        main_pc_d    = '0;
                        main_pcn_d   = STEP;
                        main_instr_d = '0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d      = ONE;
                        main_pc_d    = skid_pc_q;
                        main_pcn_d   = skid_pcn_q;
                        main_instr_d = skid_instr_q;
                        skid_pc_d    = '0;
                        skid_pcn_d   = STEP;
                        skid_instr_d = '0;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            main_pc_q    <= '0;
            main_pcn_q   <= STEP;
            main_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_pcn_q   <= STEP;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            main_pc_q    <= main_pc_d;
            main_pcn_q   <= main_pcn_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_pcn_q   <= skid_pcn_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign bus.in_ready    = (state_q != FULL);
    assign bus.out_valid   = (state_q != EMPTY);
    assign bus.out_pc      = main_pc_q;
    assign bus.out_pc_next = main_pcn_q;
    assign bus.out_instr   = main_instr_q;
    assign bus.occupancy   = state_q;
endmodule

// File: tb/tb_ifid_skid_reg.sv
// tb/tb_ifid_skid_reg.sv - directed bench with a queue model of the IF/ID skid register
module tb_ifid_skid_reg;
    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ifid_skid_reg_if #(.PC_W(32), .INSTR_W(32)) bus ();
    ifid_skid_reg_if #(.PC_W(16), .INSTR_W(32)) bus16 ();

    ifid_skid_reg #(.PC_W(32), .INSTR_W(32), .PC_STEP(4)) dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus)
    );
    ifid_skid_reg #(.PC_W(16), .INSTR_W(32), .PC_STEP(2)) dut16 (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus16)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } beat_t;

    beat_t       q[$];
    logic [31:0] popped[$];
    bit          m_acc;
    bit          m_pop;

    // Model: a FIFO of at most two beats; head is what decode sees
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
        end else begin
            m_acc = bus.in_valid && (q.size() < 2);
            m_pop = (q.size() > 0) && bus.out_ready;
            if (m_pop) popped.push_back(q[0].pc);
            if (flush) begin
                q.delete();
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_acc) q.push_back('{pc: bus.in_pc, instr: bus.in_instr});
            end
        end
    end

    logic        e_valid, e_ready;
    logic [31:0] e_pc, e_pcn, e_instr;
    logic [1:0]  e_occ;

    always @(posedge clk) begin
        e_valid = (q.size() != 0);
        e_ready = (q.size() < 2);
        e_occ   = 2'(q.size());
        e_pc    = e_valid ? q[0].pc : 32'h0;
        e_pcn   = e_valid ? q[0].pc + 32'd4 : 32'd4;
        e_instr = e_valid ? q[0].instr : 32'h0;
        tests++;
        if ({bus.out_valid, bus.in_ready, bus.occupancy, bus.out_pc, bus.out_pc_next, bus.out_instr}
            !== {e_valid, e_ready, e_occ, e_pc, e_pcn, e_instr}) begin
            fails++;
            $display("FAIL model t=%0t got v=%b r=%b occ=%0d pc=%h pcn=%h ins=%h want v=%b r=%b occ=%0d pc=%h pcn=%h ins=%h",
                     $time, bus.out_valid, bus.in_ready, bus.occupancy, bus.out_pc, bus.out_pc_next,
                     bus.out_instr, e_valid, e_ready, e_occ, e_pc, e_pcn, e_instr);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then wait past the falling edge that consumes them
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        bus.out_ready = rdy;
        flush         = fl;
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.in_pc = '0; bus16.in_instr = '0; bus16.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_occ", 32'(bus.occupancy), 32'd0);
        check("rst_pc", bus.out_pc, 32'h0);
        check("rst_pcn", bus.out_pc_next, 32'd4);
        check("rst_instr", bus.out_instr, 32'h0);
        check("rst_pcn16", 32'(bus16.out_pc_next), 32'd2);
        reset = 1'b0;
        @(negedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 1'b1, 1'b0);
            check("stream_pc", bus.out_pc, 32'h100 + 32'(4 * i));
            check("stream_pcn", bus.out_pc_next, 32'h104 + 32'(4 * i));
            check("stream_occ", 32'(bus.occupancy), 32'd1);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("drain_valid", 32'(bus.out_valid), 32'd0);
        check("drain_pc", bus.out_pc, 32'h0);
        check("drain_pcn", bus.out_pc_next, 32'd4);
        check("drain_instr", bus.out_instr, 32'h0);
        check("stream_count", 32'(popped.size()), 32'd8);

        popped.delete();
        step(1'b1, 32'h200, 32'hB200, 1'b0, 1'b0);
        check("stall1_occ", 32'(bus.occupancy), 32'd1);
        check("stall1_ready", 32'(bus.in_ready), 32'd1);
        step(1'b1, 32'h204, 32'hB204, 1'b0, 1'b0);
        check("stall2_occ", 32'(bus.occupancy), 32'd2);
        check("stall2_ready", 32'(bus.in_ready), 32'd0);
        step(1'b1, 32'h208, 32'hB208, 1'b0, 1'b0);
        check("stall3_pc", bus.out_pc, 32'h200);
        step(1'b1, 32'h208, 32'hB208, 1'b1, 1'b0);
        check("resume_pc", bus.out_pc, 32'h204);
        check("resume_ready", 32'(bus.in_ready), 32'd1);
        step(1'b1, 32'h208, 32'hB208, 1'b1, 1'b0);
        check("resume2_pc", bus.out_pc, 32'h208);
        check("resume2_instr", bus.out_instr, 32'hB208);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("skid_count", 32'(popped.size()), 32'd3);
        if (popped.size() == 3) begin
            check("skid_order0", popped[0], 32'h200);
            check("skid_order1", popped[1], 32'h204);
            check("skid_order2", popped[2], 32'h208);
        end

        step(1'b1, 32'h300, 32'hC300, 1'b0, 1'b0);
        step(1'b1, 32'h304, 32'hC304, 1'b0, 1'b0);
        check("preflush_occ", 32'(bus.occupancy), 32'd2);
        step(1'b1, 32'h308, 32'hC308, 1'b0, 1'b1);
        check("flush_occ", 32'(bus.occupancy), 32'd0);
        check("flush_pc", bus.out_pc, 32'h0);
        check("flush_instr", bus.out_instr, 32'h0);
        step(1'b1, 32'h400, 32'hC400, 1'b0, 1'b0);
        step(1'b1, 32'h404, 32'hC404, 1'b1, 1'b1);
        check("flush1_occ", 32'(bus.occupancy), 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("flush_dropped", 32'(bus.out_valid), 32'd0);

        bus16.in_valid = 1'b1;
        bus16.in_pc    = 16'hFFFE;
        step(1'b1, 32'hFFFF_FFFC, 32'hD000, 1'b0, 1'b0);
        bus16.in_valid = 1'b0;
        check("wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
        check("wrap_pcn", bus.out_pc_next, 32'h0);
        check("wrap16_pc", 32'(bus16.out_pc), 32'h0000_FFFE);
        check("wrap16_pcn", 32'(bus16.out_pc_next), 32'h0);

        step(1'b1, 32'h500, 32'hE500, 1'b0, 1'b0);
        check("prerst_occ", 32'(bus.occupancy), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_ready", 32'(bus.in_ready), 32'd1);
        check("arst_occ", 32'(bus.occupancy), 32'd0);
        check("arst_pc", bus.out_pc, 32'h0);
        check("arst_pcn", bus.out_pc_next, 32'd4);
        check("arst_instr", bus.out_instr, 32'h0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 32'h600, 32'hF600, 1'b1, 1'b0);
        check("post_rst_pc", bus.out_pc, 32'h600);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
